// File: rtl/cpu_sequencer_if.sv
// Purpose : bundles the memory-side inputs and decoder-side outputs of the multicycle sequencer.
// Latency : n/a (signal bundle only).
// Backpressure : waitrequest from memory stalls the sequencer in FETCH and MEM.
// Ports   : master = sequencer side (drives state/instr/strobes/counters),
//           slave  = memory/datapath side (drives waitrequest/readdata/pc_next).
interface cpu_sequencer_if;
   logic        waitrequest;
   logic [31:0] readdata;
   logic [31:0] pc_next;
   logic [2:0]  state;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [4:0]  b_code;
   logic [5:0]  function_code;
   logic        pc_en;
   logic        retire;
   logic        active;
   logic [31:0] cycle_count;
   logic [31:0] instr_count;

   modport master (
      input  waitrequest, readdata, pc_next,
      output state, instr, opcode, b_code, function_code,
             pc_en, retire, active, cycle_count, instr_count
   );

   modport slave (
      output waitrequest, readdata, pc_next,
      input  state, instr, opcode, b_code, function_code,
             pc_en, retire, active, cycle_count, instr_count
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Purpose : MIPS multicycle sequencer: FETCH/EXEC/MEM/HALT state, instruction register, PC strobe, counters.
// Latency : 2 cycles per non-memory instruction, 3 per memory instruction, +1 per waitrequest cycle.
// Backpressure : waitrequest=1 holds FETCH or MEM; ignored in EXEC and HALT.
// Ports   : clk, reset (async active-low), bus (cpu_sequencer_if.master).
module cpu_sequencer #(
   parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   cpu_sequencer_if.master    bus
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_MEM   = 3'd1,
      S_EXEC  = 3'd2,
      S_HALT  = 3'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] instr_q;
   logic [31:0] cycle_count_q;
   logic [31:0] instr_count_q;
   logic        active_q;
   logic        load_ir;
   logic        final_cycle;
   logic        is_mem_op;
   logic [5:0]  op;

   assign op = instr_q[31:26];

   // Loads and stores need the extra MEM cycle.
   always_comb begin
      is_mem_op = 1'b0;
      case (op)
         6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
         6'd37, 6'd38, 6'd40, 6'd41, 6'd43: is_mem_op = 1'b1;
         default:                           is_mem_op = 1'b0;
      endcase
   end

   // Next-state and strobe decode. final_cycle marks the retiring cycle of an
   // instruction; it alone drives pc_en/retire and the HALT/FETCH choice.
   always_comb begin
      state_d     = state_q;
      load_ir     = 1'b0;
      final_cycle = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (!bus.waitrequest) begin
               load_ir = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_mem_op) begin
               state_d = S_MEM;
            end else begin
               final_cycle = 1'b1;
               state_d     = (bus.pc_next == 32'd0) ? S_HALT : S_FETCH;
            end
         end
         S_MEM: begin
            if (!bus.waitrequest) begin
               final_cycle = 1'b1;
               state_d     = (bus.pc_next == 32'd0) ? S_HALT : S_FETCH;
            end
         end
         S_HALT:  state_d = S_HALT;
         // Encodings 4-7 recover to FETCH on the next edge.
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_FETCH;
         instr_q       <= RESET_IR;
         active_q      <= 1'b1;
         cycle_count_q <= 32'd0;
         instr_count_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         // active falls on the edge that enters HALT, one cycle after the halting retire.
         active_q <= (state_d != S_HALT);
         if (load_ir) begin
            instr_q <= bus.readdata;
         end
         // Counters wrap naturally at 2^32.
         if (state_q != S_HALT) begin
            cycle_count_q <= cycle_count_q + 32'd1;
         end
         if (final_cycle) begin
            instr_count_q <= instr_count_q + 32'd1;
         end
      end
   end

   assign bus.state         = state_q;
   assign bus.instr         = instr_q;
   assign bus.opcode        = instr_q[31:26];
   assign bus.b_code        = instr_q[20:16];
   assign bus.function_code = instr_q[5:0];
   assign bus.pc_en         = final_cycle;
   assign bus.retire        = final_cycle;
   assign bus.active        = active_q;
   assign bus.cycle_count   = cycle_count_q;
   assign bus.instr_count   = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Purpose : directed, table-driven bench for cpu_sequencer.
// Latency : n/a.
// Backpressure : waitrequest driven directly from the vectors.
module tb_cpu_sequencer;

   localparam logic [31:0] I_ADDU = 32'h0022_1821; // addu $3,$1,$2
   localparam logic [31:0] I_LW   = 32'h8C85_0010; // lw  $5,16($4)
   localparam logic [31:0] I_SW   = 32'hAC85_0010; // sw  $5,16($4)
   localparam logic [31:0] I_JR   = 32'h03E0_0008; // jr  $31

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   cpu_sequencer_if sif ();

   cpu_sequencer #(.RESET_IR(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] rd;
      logic [31:0] pcn;
      logic [2:0]  st;
      logic        pe;
      logic        act;
      logic [31:0] cc;
      logic [31:0] ic;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sif.waitrequest = 1'b1;
      sif.readdata    = 32'd0;
      sif.pc_next     = 32'd4;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic add(input logic wr, input logic [31:0] rd, input logic [31:0] pcn,
                      input logic [2:0] st, input logic pe, input logic act,
                      input logic [31:0] cc, input logic [31:0] ic);
      vec_t v;
      v.wr = wr; v.rd = rd; v.pcn = pcn; v.st = st;
      v.pe = pe; v.act = act; v.cc = cc; v.ic = ic;
      vt.push_back(v);
   endtask

   initial begin
      logic [31:0] cc_hold;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      sif.waitrequest = 1'b1;
      sif.readdata    = 32'd0;
      sif.pc_next     = 32'd4;

      // ADDU no stall, LW with 3 FETCH + 2 MEM stalls, SW halting from MEM.
      //  wr    readdata pc_next st pe act cc  ic
      add(1'b0, I_ADDU, 32'd4, 3'd0, 1'b0, 1'b1, 32'd0,  32'd0);
      add(1'b0, I_ADDU, 32'd4, 3'd2, 1'b1, 1'b1, 32'd1,  32'd0);
      add(1'b1, I_LW,   32'd8, 3'd0, 1'b0, 1'b1, 32'd2,  32'd1);
      add(1'b1, I_LW,   32'd8, 3'd0, 1'b0, 1'b1, 32'd3,  32'd1);
      add(1'b1, I_LW,   32'd8, 3'd0, 1'b0, 1'b1, 32'd4,  32'd1);
      add(1'b0, I_LW,   32'd8, 3'd0, 1'b0, 1'b1, 32'd5,  32'd1);
      add(1'b1, 32'd0,  32'd8, 3'd2, 1'b0, 1'b1, 32'd6,  32'd1);
      add(1'b1, 32'd0,  32'd8, 3'd1, 1'b0, 1'b1, 32'd7,  32'd1);
      add(1'b1, 32'd0,  32'd8, 3'd1, 1'b0, 1'b1, 32'd8,  32'd1);
      add(1'b0, 32'd0,  32'd8, 3'd1, 1'b1, 1'b1, 32'd9,  32'd1);
      add(1'b0, I_SW,   32'd0, 3'd0, 1'b0, 1'b1, 32'd10, 32'd2);
      add(1'b0, 32'd0,  32'd0, 3'd2, 1'b0, 1'b1, 32'd11, 32'd2);
      add(1'b0, 32'd0,  32'd0, 3'd1, 1'b1, 1'b1, 32'd12, 32'd2);
      add(1'b1, I_ADDU, 32'd4, 3'd3, 1'b0, 1'b0, 32'd13, 32'd3);
      add(1'b0, I_ADDU, 32'd4, 3'd3, 1'b0, 1'b0, 32'd13, 32'd3);
      add(1'b1, I_LW,   32'd0, 3'd3, 1'b0, 1'b0, 32'd13, 32'd3);

      do_reset();
      chk("reset_instr", sif.instr, 32'd0);
      chk("reset_pc_en", {31'd0, sif.pc_en}, 32'd0);

      for (int i = 0; i < vt.size(); i++) begin
         sif.waitrequest = vt[i].wr;
         sif.readdata    = vt[i].rd;
         sif.pc_next     = vt[i].pcn;
         #1;
         chk($sformatf("v%0d_state", i),  {29'd0, sif.state},  {29'd0, vt[i].st});
         chk($sformatf("v%0d_pc_en", i),  {31'd0, sif.pc_en},  {31'd0, vt[i].pe});
         chk($sformatf("v%0d_retire", i), {31'd0, sif.retire}, {31'd0, vt[i].pe});
         chk($sformatf("v%0d_active", i), {31'd0, sif.active}, {31'd0, vt[i].act});
         chk($sformatf("v%0d_cycles", i), sif.cycle_count, vt[i].cc);
         chk($sformatf("v%0d_instrs", i), sif.instr_count, vt[i].ic);
         tick();
      end
      chk("halt_instr_frozen", sif.instr, I_SW);

      // JR with pc_next = 0: halt from EXEC, then frozen for 10 cycles.
      do_reset();
      sif.waitrequest = 1'b0;
      sif.readdata    = I_JR;
      sif.pc_next     = 32'd0;
      tick();
      sif.readdata = 32'hDEAD_BEEF;
      #1;
      chk("jr_state_exec", {29'd0, sif.state}, 32'd2);
      chk("jr_instr", sif.instr, I_JR);
      chk("jr_opcode", {26'd0, sif.opcode}, 32'd0);
      chk("jr_funct", {26'd0, sif.function_code}, 32'd8);
      chk("jr_b_code", {27'd0, sif.b_code}, 32'd0);
      chk("jr_pc_en", {31'd0, sif.pc_en}, 32'd1);
      chk("jr_retire", {31'd0, sif.retire}, 32'd1);
      chk("jr_active_exec", {31'd0, sif.active}, 32'd1);
      tick();
      chk("jr_state_halt", {29'd0, sif.state}, 32'd3);
      chk("jr_active_halt", {31'd0, sif.active}, 32'd0);
      chk("jr_icount", sif.instr_count, 32'd1);
      chk("jr_ccount", sif.cycle_count, 32'd2);
      for (int k = 0; k < 10; k++) begin
         sif.waitrequest = k[0];
         sif.readdata    = $urandom;
         sif.pc_next     = 32'd4;
         #1;
         chk($sformatf("halt%0d_pc_en", k), {31'd0, sif.pc_en}, 32'd0);
         tick();
         chk($sformatf("halt%0d_ccount", k), sif.cycle_count, 32'd2);
         chk($sformatf("halt%0d_icount", k), sif.instr_count, 32'd1);
         chk($sformatf("halt%0d_instr", k), sif.instr, I_JR);
         chk($sformatf("halt%0d_state", k), {29'd0, sif.state}, 32'd3);
      end

      // Reset asserted mid-MEM stall must clear outputs without a clock edge.
      do_reset();
      sif.waitrequest = 1'b0;
      sif.readdata    = I_LW;
      sif.pc_next     = 32'd8;
      tick();                      // now EXEC
      sif.waitrequest = 1'b1;
      tick();                      // now MEM, stalled
      tick();                      // still MEM
      chk("mid_state_mem", {29'd0, sif.state}, 32'd1);
      chk("mid_opcode", {26'd0, sif.opcode}, 32'd35);
      chk("mid_b_code", {27'd0, sif.b_code}, 32'd5);
      chk("mid_funct", {26'd0, sif.function_code}, 32'h10);
      chk("mid_pc_en_stall", {31'd0, sif.pc_en}, 32'd0);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_state", {29'd0, sif.state}, 32'd0);
      chk("arst_instr", sif.instr, 32'd0);
      chk("arst_ccount", sif.cycle_count, 32'd0);
      chk("arst_icount", sif.instr_count, 32'd0);
      chk("arst_active", {31'd0, sif.active}, 32'd1);
      chk("arst_pc_en", {31'd0, sif.pc_en}, 32'd0);
      tick();
      reset = 1'b1;
      sif.waitrequest = 1'b0;
      sif.readdata    = I_ADDU;
      tick();
      chk("post_rst_exec", {29'd0, sif.state}, 32'd2);
      chk("post_rst_instr", sif.instr, I_ADDU);

      // cycle_count wrap while stalled in FETCH.
      do_reset();
      sif.waitrequest = 1'b1;
      tick();
      force dut.cycle_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_count_q;
      tick();
      chk("wrap_ccount", sif.cycle_count, 32'd0);
      chk("wrap_icount", sif.instr_count, 32'd0);
      tick();
      chk("wrap_ccount_next", sif.cycle_count, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
